// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle RV32I core: sequences fetch, decode,
// execute, memory and write-back and drives the datapath strobes.
module multicycle_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] inst_code,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  input  logic        branch_taken,
  output logic        imem_req,
  output logic        ir_load,
  output logic        pc_write,
  output logic        pc_src,
  output logic        alu_src_imm,
  output logic [1:0]  alu_op,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        reg_write,
  output logic [1:0]  wb_sel,
  output logic        illegal,
  output logic [2:0]  state,
  output logic [31:0] instr_count
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  state_t      r_state;
  state_t      w_next;
  logic [6:0]  r_opcode;
  logic [31:0] r_instr_count;
  logic        r_illegal;
  logic        w_legal;
  logic        w_unused_inst;

  logic       w_imem_req, w_ir_load, w_pc_write, w_pc_src, w_alu_src_imm;
  logic       w_dmem_req, w_dmem_we, w_reg_write;
  logic [1:0] w_alu_op, w_wb_sel;

  assign w_unused_inst = ^inst_code[31:7];
  assign w_legal = inst_code[6:0] inside {OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_FETCH;
      r_opcode      <= '0;
      r_instr_count <= '0;
      r_illegal     <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) begin
        r_opcode <= inst_code[6:0];
        if (!w_legal) r_illegal <= 1'b1;
      end
      if (w_pc_write) r_instr_count <= r_instr_count + 32'd1;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:  if (imem_ready) w_next = S_DECODE;
      S_DECODE: w_next = w_legal ? S_EXEC : S_TRAP;
      S_EXEC: begin
        case (r_opcode)
          OP_R, OP_I, OP_JAL:  w_next = S_WB;
          OP_LOAD, OP_STORE:   w_next = S_MEM;
          OP_BRANCH:           w_next = S_FETCH;
          default:             w_next = S_TRAP;
        endcase
      end
      S_MEM:  if (dmem_ready) w_next = (r_opcode == OP_LOAD) ? S_WB : S_FETCH;
      S_WB:   w_next = S_FETCH;
      S_TRAP: w_next = S_TRAP;
      default: w_next = S_FETCH;
    endcase
  end

  always_comb begin
    w_imem_req    = 1'b0;
    w_ir_load     = 1'b0;
    w_pc_write    = 1'b0;
    w_pc_src      = 1'b0;
    w_alu_src_imm = 1'b0;
    w_alu_op      = 2'b00;
    w_dmem_req    = 1'b0;
    w_dmem_we     = 1'b0;
    w_reg_write   = 1'b0;
    w_wb_sel      = 2'b00;
    case (r_state)
      S_FETCH: begin
        w_imem_req = 1'b1;
        w_ir_load  = imem_ready;
      end
      S_EXEC: begin
        case (r_opcode)
          OP_R: w_alu_op = 2'b10;
          OP_I: begin
            w_alu_op      = 2'b10;
            w_alu_src_imm = 1'b1;
          end
          OP_LOAD, OP_STORE: w_alu_src_imm = 1'b1;
          OP_BRANCH: begin
            w_alu_op   = 2'b01;
            w_pc_write = 1'b1;
            w_pc_src   = branch_taken;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        w_dmem_req = 1'b1;
        w_dmem_we  = (r_opcode == OP_STORE);
        w_pc_write = (r_opcode == OP_STORE) && dmem_ready;
      end
      S_WB: begin
        w_reg_write = 1'b1;
        w_pc_write  = 1'b1;
        w_pc_src    = (r_opcode == OP_JAL);
        w_wb_sel    = (r_opcode == OP_JAL)  ? 2'b10 :
                      (r_opcode == OP_LOAD) ? 2'b01 : 2'b00;
      end
      default: ;
    endcase
  end

  // Reset masks every output so nothing (not even FETCH's imem_req) leaks while held.
  assign imem_req    = w_imem_req    & ~reset;
  assign ir_load     = w_ir_load     & ~reset;
  assign pc_write    = w_pc_write    & ~reset;
  assign pc_src      = w_pc_src      & ~reset;
  assign alu_src_imm = w_alu_src_imm & ~reset;
  assign alu_op      = reset ? 2'b00 : w_alu_op;
  assign dmem_req    = w_dmem_req    & ~reset;
  assign dmem_we     = w_dmem_we     & ~reset;
  assign reg_write   = w_reg_write   & ~reset;
  assign wb_sel      = reset ? 2'b00 : w_wb_sel;
  assign illegal     = r_illegal     & ~reset;
  assign state       = reset ? 3'd0 : r_state;
  assign instr_count = reset ? '0 : r_instr_count;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl.
module tb_multicycle_ctrl;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] inst_code = '0;
  logic        imem_ready = 1'b0, dmem_ready = 1'b0, branch_taken = 1'b0;
  logic        imem_req, ir_load, pc_write, pc_src, alu_src_imm;
  logic        dmem_req, dmem_we, reg_write, illegal;
  logic [1:0]  alu_op, wb_sel;
  logic [2:0]  state;
  logic [31:0] instr_count;

  int checks = 0;
  int failures = 0;
  int excl_bad = 0;

  // per-run observations from run_instr
  int   lat, dreq_cycles;
  logic saw_rw, saw_we, pcsrc_at, rw_at;
  logic [1:0] wb_at, aop_log [16];
  logic [2:0] st_at, st_log [16];
  logic asi_log [16];

  multicycle_ctrl dut (
    .clk(clk), .reset(reset), .inst_code(inst_code), .imem_ready(imem_ready),
    .dmem_ready(dmem_ready), .branch_taken(branch_taken), .imem_req(imem_req),
    .ir_load(ir_load), .pc_write(pc_write), .pc_src(pc_src), .alu_src_imm(alu_src_imm),
    .alu_op(alu_op), .dmem_req(dmem_req), .dmem_we(dmem_we), .reg_write(reg_write),
    .wb_sel(wb_sel), .illegal(illegal), .state(state), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (int'(reg_write) + int'(dmem_we) + int'(ir_load) > 1) excl_bad++;

  task automatic do_reset();
    reset = 1'b1; imem_ready = 1'b0; dmem_ready = 1'b0; branch_taken = 1'b0; inst_code = '0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // Runs one instruction from FETCH until its pc_write cycle (bounded); leaves time at edge+1.
  task automatic run_instr(input logic [31:0] inst, input int iwait, input int dwait, input logic bt);
    int icnt = 0, dcnt = 0;
    inst_code = inst; branch_taken = bt;
    lat = -1; dreq_cycles = 0; saw_rw = 1'b0; saw_we = 1'b0;
    wb_at = 2'b11; pcsrc_at = 1'bx; rw_at = 1'bx; st_at = 3'd7;
    for (int c = 0; c < 50; c++) begin
      if (imem_req) begin imem_ready = (icnt >= iwait); icnt++; end else imem_ready = 1'b1;
      if (dmem_req) begin dmem_ready = (dcnt >= dwait); dcnt++; end else dmem_ready = 1'b1;
      #1;
      if (c < 16) begin st_log[c] = state; aop_log[c] = alu_op; asi_log[c] = alu_src_imm; end
      if (dmem_req)  dreq_cycles++;
      if (reg_write) saw_rw = 1'b1;
      if (dmem_we)   saw_we = 1'b1;
      if (pc_write) begin
        lat = c + 1; wb_at = wb_sel; pcsrc_at = pc_src; rw_at = reg_write; st_at = state;
      end
      @(posedge clk); #1;
      if (lat >= 0) break;
    end
    imem_ready = 1'b0; dmem_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; imem_ready = 1'b1; dmem_ready = 1'b1;
    @(posedge clk); #1; @(posedge clk); #1;
    checks++; if (state !== 3'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state); end
    checks++; if ({imem_req, ir_load, pc_write, pc_src, alu_src_imm, alu_op, dmem_req, dmem_we, reg_write, wb_sel, illegal} !== '0) begin
      failures++; $display("FAIL reset_strobes got=nonzero exp=0"); end
    checks++; if (instr_count !== 32'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", instr_count); end
    imem_ready = 1'b0; dmem_ready = 1'b0;
    reset = 1'b0; #1;
    checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL release_imem_req got=%b exp=1", imem_req); end
  endtask

  task automatic test_addi();
    run_instr(32'h00500093, 0, 0, 1'b0);
    checks++; if (lat !== 4) begin failures++; $display("FAIL addi_latency got=%0d exp=4", lat); end
    checks++; if ({st_log[0], st_log[1], st_log[2], st_log[3]} !== {3'd0, 3'd1, 3'd2, 3'd4}) begin
      failures++; $display("FAIL addi_states got=%0d,%0d,%0d,%0d exp=0,1,2,4", st_log[0], st_log[1], st_log[2], st_log[3]); end
    checks++; if (aop_log[2] !== 2'b10 || asi_log[2] !== 1'b1) begin
      failures++; $display("FAIL addi_exec got=alu_op %b imm %b exp=10 1", aop_log[2], asi_log[2]); end
    checks++; if (rw_at !== 1'b1 || wb_at !== 2'b00 || pcsrc_at !== 1'b0) begin
      failures++; $display("FAIL addi_wb got=rw %b wb %b pcsrc %b exp=1 00 0", rw_at, wb_at, pcsrc_at); end
    checks++; if (instr_count !== 32'd1) begin failures++; $display("FAIL addi_count got=%0d exp=1", instr_count); end
  endtask

  task automatic test_load_wait();
    run_instr(32'h0000A103, 0, 3, 1'b0);
    checks++; if (lat !== 8) begin failures++; $display("FAIL lw_latency got=%0d exp=8", lat); end
    checks++; if (dreq_cycles !== 4) begin failures++; $display("FAIL lw_dreq_cycles got=%0d exp=4", dreq_cycles); end
    checks++; if (saw_we !== 1'b0) begin failures++; $display("FAIL lw_dmem_we got=%b exp=0", saw_we); end
    checks++; if (wb_at !== 2'b01 || st_at !== 3'd4) begin
      failures++; $display("FAIL lw_wb got=wb %b state %0d exp=01 4", wb_at, st_at); end
    checks++; if (instr_count !== 32'd2) begin failures++; $display("FAIL lw_count got=%0d exp=2", instr_count); end
  endtask

  task automatic test_store_branch();
    do_reset();
    run_instr(32'h0020A023, 0, 0, 1'b0);
    checks++; if (lat !== 4 || st_at !== 3'd3) begin
      failures++; $display("FAIL sw_retire got=lat %0d state %0d exp=4 3", lat, st_at); end
    checks++; if (saw_we !== 1'b1 || saw_rw !== 1'b0 || pcsrc_at !== 1'b0) begin
      failures++; $display("FAIL sw_strobes got=we %b rw %b pcsrc %b exp=1 0 0", saw_we, saw_rw, pcsrc_at); end
    run_instr(32'h00208463, 0, 0, 1'b1);
    checks++; if (lat !== 3 || st_at !== 3'd2) begin
      failures++; $display("FAIL beq_retire got=lat %0d state %0d exp=3 2", lat, st_at); end
    checks++; if (pcsrc_at !== 1'b1 || saw_rw !== 1'b0 || aop_log[2] !== 2'b01 || asi_log[2] !== 1'b0) begin
      failures++; $display("FAIL beq_strobes got=pcsrc %b rw %b op %b imm %b exp=1 0 01 0", pcsrc_at, saw_rw, aop_log[2], asi_log[2]); end
    checks++; if (instr_count !== 32'd2) begin failures++; $display("FAIL sw_beq_count got=%0d exp=2", instr_count); end
  endtask

  task automatic test_jal_and_fetch_wait();
    run_instr(32'h0080006F, 0, 0, 1'b0);
    checks++; if (lat !== 4 || wb_at !== 2'b10 || pcsrc_at !== 1'b1 || rw_at !== 1'b1) begin
      failures++; $display("FAIL jal_wb got=lat %0d wb %b pcsrc %b rw %b exp=4 10 1 1", lat, wb_at, pcsrc_at, rw_at); end
    run_instr(32'h00208463, 2, 0, 1'b0);
    checks++; if (lat !== 5 || pcsrc_at !== 1'b0) begin
      failures++; $display("FAIL beq_nt_wait got=lat %0d pcsrc %b exp=5 0", lat, pcsrc_at); end
  endtask

  task automatic test_illegal();
    int bad = 0;
    do_reset();
    inst_code = 32'h000000B7; imem_ready = 1'b1;
    @(posedge clk); #1; @(posedge clk); #1;
    checks++; if (state !== 3'd5 || illegal !== 1'b1) begin
      failures++; $display("FAIL lui_trap got=state %0d illegal %b exp=5 1", state, illegal); end
    for (int i = 0; i < 20; i++) begin
      if (state !== 3'd5 || illegal !== 1'b1 ||
          {imem_req, ir_load, pc_write, dmem_req, dmem_we, reg_write} !== '0) bad++;
      @(posedge clk); #1;
    end
    checks++; if (bad !== 0) begin failures++; $display("FAIL trap_hold got=%0d bad cycles exp=0", bad); end
    reset = 1'b1; #1;
    checks++; if (illegal !== 1'b0) begin failures++; $display("FAIL trap_reset_illegal got=%b exp=0", illegal); end
    @(posedge clk); #1; reset = 1'b0; imem_ready = 1'b0; #1;
    checks++; if (state !== 3'd0 || imem_req !== 1'b1 || illegal !== 1'b0) begin
      failures++; $display("FAIL trap_resume got=state %0d req %b ill %b exp=0 1 0", state, imem_req, illegal); end
  endtask

  task automatic test_mem_reset();
    do_reset();
    inst_code = 32'h0000A103; imem_ready = 1'b1; dmem_ready = 1'b0;
    @(posedge clk); #1; @(posedge clk); #1; @(posedge clk); #1;
    checks++; if (state !== 3'd3 || dmem_req !== 1'b1) begin
      failures++; $display("FAIL mem_entry got=state %0d dreq %b exp=3 1", state, dmem_req); end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b1; #1;
    checks++; if (state !== 3'd0 || dmem_req !== 1'b0 || imem_req !== 1'b1) begin
      failures++; $display("FAIL mem_abandon got=state %0d dreq %b ireq %b exp=0 0 1", state, dmem_req, imem_req); end
    @(posedge clk); #1;
    checks++; if (state !== 3'd0 || instr_count !== 32'd0) begin
      failures++; $display("FAIL stray_dready got=state %0d cnt %0d exp=0 0", state, instr_count); end
    dmem_ready = 1'b0;
  endtask

  task automatic test_wrap();
    do_reset();
    force dut.r_instr_count = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    release dut.r_instr_count;
    #1;
    checks++; if (instr_count !== 32'hFFFF_FFFF) begin
      failures++; $display("FAIL wrap_preload got=%h exp=ffffffff", instr_count); end
    run_instr(32'h00208463, 0, 0, 1'b0);
    checks++; if (instr_count !== 32'd0) begin failures++; $display("FAIL wrap_count got=%h exp=0", instr_count); end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_load_wait();
    test_store_branch();
    test_jal_and_fetch_wait();
    test_illegal();
    test_mem_reset();
    test_wrap();
    checks++; if (excl_bad !== 0) begin failures++; $display("FAIL strobe_exclusive got=%0d cycles exp=0", excl_bad); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Main control FSM for the multi-cycle RV32I core. It sequences each instruction through fetch, decode, execute, memory and write-back. It drives the PC, instruction register, ALU-operand and write-back muxes, and the instruction/data memory request handshakes. The immediate generator decodes its own opcode; this block only selects its output as ALU operand B or the PC target.

## Interface
- No parameters.
- clk  input  1  core clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high.
- inst_code  input  32  instruction register contents; stable from the cycle after ir_load.
- imem_ready  input  1  instruction memory done; valid only while imem_req=1.
- dmem_ready  input  1  data memory done; valid only while dmem_req=1.
- branch_taken  input  1  ALU compare result; valid in EXEC.
- imem_req  output  1  instruction fetch request.
- ir_load  output  1  latch instruction register.
- pc_write  output  1  update PC; one-cycle pulse per retired instruction.
- pc_src  output  1  0 = PC+4, 1 = PC+imm.
- alu_src_imm  output  1  ALU B operand: 1 = immediate, 0 = rs2.
- alu_op  output  2  00 add, 01 branch compare, 10 funct3/funct7 decoded.
- dmem_req  output  1  data memory request.
- dmem_we  output  1  store strobe; qualifies dmem_req.
- reg_write  output  1  register file write enable.
- wb_sel  output  2  00 ALU, 01 memory, 10 PC+4.
- illegal  output  1  sticky unsupported-opcode flag.
- state  output  3  current FSM state (debug).
- instr_count  output  32  retired-instruction counter.

## Operation
- Supported opcodes: 0110011 R, 0010011 I-arith, 0000011 load, 0100011 store, 1100011 branch, 1101111 JAL. Any other opcode is illegal.
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5.
- **FETCH**
  - imem_req=1.
  - If imem_ready=1: ir_load=1 and go to DECODE. Otherwise stay in FETCH.
- **DECODE**
  - Capture opcode (inst_code[6:0]) into an internal register.
  - Illegal opcode: go to TRAP. Otherwise go to EXEC.
- **EXEC**, per captured opcode:
  - R-type: alu_op=10, alu_src_imm=0, go to WB.
  - I-arith: alu_op=10, alu_src_imm=1, go to WB.
  - Load or store: alu_op=00, alu_src_imm=1, go to MEM.
  - Branch: alu_op=01, alu_src_imm=0, pc_write=1, pc_src=branch_taken, retire, go to FETCH.
  - JAL: go to WB.
- **MEM**
  - dmem_req=1; dmem_we=1 for store only.
  - On dmem_ready: a load goes to WB; a store sets pc_write=1, pc_src=0, retires and goes to FETCH.
  - No ready: stay in MEM.
- **WB**
  - reg_write=1 and pc_write=1, then go to FETCH.
  - wb_sel: 00 for R/I, 01 for load, 10 for JAL.
  - pc_src: 1 for JAL, else 0.
- **TRAP**
  - illegal=1, all other strobes 0.
  - Stays in TRAP until reset.
- Outputs not listed for a state are 0.
- instr_count increments by 1 on every cycle with pc_write=1. It wraps from 0xFFFFFFFF to 0.

## Timing
- Outputs are combinational from the state register and the captured opcode. They are not a function of inst_code except in DECODE.
- Reset: state=FETCH, captured opcode=0, instr_count=0, illegal=0.
  - While reset=1, all outputs read 0 and the state register shows 0.
  - First cycle after release: imem_req=1.
  - Reset asserted in any state, including MEM mid-handshake or TRAP, returns the block to FETCH on the next edge. An outstanding memory request is abandoned.
- Handshake: req stays high until ready is sampled 1 on an edge, then drops the next cycle. A ready seen while req=0 is ignored.
- Latency with zero-wait memories, counted from the first FETCH cycle to the pc_write cycle inclusive:
  - Branch: 3 cycles.
  - R, I-arith, JAL, store: 4 cycles.
  - Load: 5 cycles.
- Each memory wait cycle adds 1.
- Back-to-back instructions: FETCH starts the cycle after pc_write. There is no overlap.
- Exactly one of reg_write, dmem_we, ir_load is asserted in any cycle, or none.

## Test plan
- Reset release, imem_ready=1 constant, ADDI 0x00500093: states 0,1,2,4. In EXEC, alu_src_imm=1 and alu_op=10. In WB, reg_write=1, wb_sel=00, pc_write=1. instr_count reads 1 the cycle after.
- LW 0x0000A103 with dmem_ready delayed 3 cycles: dmem_req is high for 4 cycles and dmem_we=0. WB has wb_sel=01. Total latency is 8 cycles.
- SW 0x0020A023 followed by BEQ 0x00208463 with branch_taken=1: the store retires in MEM with dmem_we=1 and reg_write never asserts. The branch retires in EXEC with pc_src=1 and reg_write=0. instr_count reaches 2.
- JAL 0x0080006F: WB has wb_sel=10, pc_src=1, reg_write=1.
- Opcode 0110111 (LUI, unsupported): DECODE goes to TRAP, illegal=1 and stays high for 20 cycles with all strobes 0. Asserting reset clears illegal and resumes FETCH.
- Reset asserted mid-MEM with dmem_ready=0: the next state is FETCH and dmem_req drops. Separately, preload instr_count=0xFFFFFFFF via a forced run; one more retire wraps it to 0.
